// File: rtl/digit_entry_buffer.sv
// Digit-entry buffer for the 8-digit seven-segment scan driver: push/backspace/clear
// editing of an 8-nibble hex entry with a blinking newest-digit cursor on AN_MASK.
module digit_entry_buffer #(
  parameter int          DROP_OLDEST = 1,
  parameter int unsigned BLINK_BITS  = 24
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [3:0]  DIGIT,
  input  logic        PUSH,
  input  logic        POP,
  input  logic        CLEAR,
  input  logic        BLINK_EN,
  output logic [31:0] NUMBER,
  output logic [7:0]  AN_MASK,
  output logic [3:0]  COUNT,
  output logic        FULL,
  output logic        OVERFLOW
);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t                state, state_nxt;
  logic [31:0]           number_nxt;
  logic [3:0]            count_nxt;
  logic                  ovf_nxt;
  logic [BLINK_BITS-1:0] blink_cnt, blink_nxt;
  logic [7:0]            mask_nxt;

  always_comb begin
    state_nxt  = state;
    number_nxt = NUMBER;
    count_nxt  = COUNT;
    ovf_nxt    = OVERFLOW;
    blink_nxt  = blink_cnt + {{(BLINK_BITS-1){1'b0}}, 1'b1};

    if (CLEAR) begin
      state_nxt  = S_EMPTY;
      number_nxt = '0;
      count_nxt  = '0;
      ovf_nxt    = 1'b0;
    end else if (POP) begin
      if (state != S_EMPTY) begin
        number_nxt = {4'h0, NUMBER[31:4]};
        count_nxt  = COUNT - 4'd1;
        state_nxt  = (COUNT == 4'd1) ? S_EMPTY : S_PARTIAL;
        blink_nxt  = '0;
      end
    end else if (PUSH) begin
      if (state == S_FULL) begin
        ovf_nxt = 1'b1;
        // A rejected push is not an executed command, so the blink phase runs on.
        if (DROP_OLDEST != 0) begin
          number_nxt = {NUMBER[27:0], DIGIT};
          blink_nxt  = '0;
        end
      end else begin
        number_nxt = {NUMBER[27:0], DIGIT};
        count_nxt  = COUNT + 4'd1;
        state_nxt  = (COUNT == 4'd7) ? S_FULL : S_PARTIAL;
        blink_nxt  = '0;
      end
    end

    // Mask is built from next-state values so AN_MASK tracks COUNT on the same edge.
    mask_nxt = '1;
    for (int unsigned i = 0; i < 8; i++) begin
      mask_nxt[i] = (4'(i) >= count_nxt);
    end
    mask_nxt[0] = mask_nxt[0] | (BLINK_EN & blink_nxt[BLINK_BITS-1] & (count_nxt != 4'd0));
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state     <= S_EMPTY;
      NUMBER    <= '0;
      COUNT     <= '0;
      OVERFLOW  <= 1'b0;
      blink_cnt <= '0;
      AN_MASK   <= '1;
    end else begin
      state     <= state_nxt;
      NUMBER    <= number_nxt;
      COUNT     <= count_nxt;
      OVERFLOW  <= ovf_nxt;
      blink_cnt <= blink_nxt;
      AN_MASK   <= mask_nxt;
    end
  end

  assign FULL = (state == S_FULL);

endmodule
